// File: rtl/vec_cache_bank_req_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : vec_cache_bank_req_arb_pkg / vec_cache_bank_req_arb_if
// Brief    : Request payload type and the bundled port interface of the
//            per-bank read/write request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package vec_cache_bank_req_arb_pkg;

    localparam int c_ROB_FIELD_W = 6;

    typedef struct packed {
        logic [31:0]              cmd_addr;
        logic [7:0]               cmd_txnid;
        logic [3:0]               cmd_sideband;
        logic [15:0]              strb;
        logic [3:0]               cmd_opcode;
        logic [5:0]               db_entry_id;
        logic [c_ROB_FIELD_W-1:0] rob_entry_id;
    } input_req_pld_t;

endpackage

interface vec_cache_bank_req_arb_if #(
    parameter int ROB_DEPTH = 16
) ();
    import vec_cache_bank_req_arb_pkg::*;

    localparam int ROB_ID_W = $clog2(ROB_DEPTH);

    logic                rd_req_vld;
    input_req_pld_t      rd_req_pld;
    logic                rd_req_rdy;
    logic                wr_req_vld;
    input_req_pld_t      wr_req_pld;
    logic                wr_req_rdy;
    logic                bank_req_vld;
    input_req_pld_t      bank_req_pld;
    logic                bank_req_rdy;
    logic                rob_rel_vld;
    logic [ROB_ID_W-1:0] rob_rel_id;
    logic [ROB_ID_W:0]   rob_free_cnt;

    // Arbiter side
    modport slave (
        input  rd_req_vld, rd_req_pld,
        output rd_req_rdy,
        input  wr_req_vld, wr_req_pld,
        output wr_req_rdy,
        output bank_req_vld, bank_req_pld,
        input  bank_req_rdy,
        input  rob_rel_vld, rob_rel_id,
        output rob_free_cnt
    );

    // Crossbar / bank pipeline side
    modport master (
        output rd_req_vld, rd_req_pld,
        input  rd_req_rdy,
        output wr_req_vld, wr_req_pld,
        input  wr_req_rdy,
        input  bank_req_vld, bank_req_pld,
        output bank_req_rdy,
        output rob_rel_vld, rob_rel_id,
        input  rob_free_cnt
    );

endinterface
`default_nettype wire

// File: rtl/vec_cache_bank_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : vec_cache_bank_req_arb
// Brief    : Per-bank round-robin arbiter between a read and a write request
//            lane, each buffered in a 2-entry FIFO, stamping granted requests
//            with a free ROB id. Optional macro VEC_CACHE_REQ_ARB_BYPASS_EN
//            lets a request skip an empty FIFO for T+1 latency.
// Revision : 1.0 - initial release
// ============================================================================
module vec_cache_bank_req_arb
    import vec_cache_bank_req_arb_pkg::*;
#(
    parameter int ROB_DEPTH = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    vec_cache_bank_req_arb_if.slave io
);

    localparam int   ROB_ID_W = $clog2(ROB_DEPTH);
    localparam logic c_SRC_RD = 1'b0;
    localparam logic c_SRC_WR = 1'b1;
`ifdef VEC_CACHE_REQ_ARB_BYPASS_EN
    localparam logic c_BYPASS = 1'b1;
`else
    localparam logic c_BYPASS = 1'b0;
`endif

    // Source index 0 = read lane, 1 = write lane
    logic [1:0]     w_in_vld;
    input_req_pld_t w_in_pld   [2];
    input_req_pld_t w_head_pld [2];
    logic [1:0]     w_rdy;
    logic [1:0]     w_push;
    logic [1:0]     w_head_vld;
    logic [1:0]     w_byp;
    logic [1:0]     w_cand;

    logic                 r_out_vld;
    input_req_pld_t       r_out_pld;
    logic                 r_last_grant;
    logic [ROB_DEPTH-1:0] r_mask;
    logic [ROB_ID_W:0]    r_free_cnt;

    logic                 w_load_ok;
    logic                 w_grant;
    logic                 w_win;
    input_req_pld_t       w_win_pld;
    input_req_pld_t       w_grant_pld;
    logic [ROB_ID_W-1:0]  w_alloc_id;
    logic [ROB_DEPTH-1:0] w_alloc_mask;
    logic                 w_rel_eff;
    logic [ROB_DEPTH-1:0] w_rel_mask;

    assign w_in_vld[0] = io.rd_req_vld;
    assign w_in_vld[1] = io.wr_req_vld;
    assign w_in_pld[0] = io.rd_req_pld;
    assign w_in_pld[1] = io.wr_req_pld;

    generate
        for (genvar s = 0; s < 2; s++) begin : g_fifo
            input_req_pld_t r_mem [2];
            logic           r_wptr;
            logic           r_rptr;
            logic [1:0]     r_cnt;
            logic           w_is_win;
            logic           w_pop;
            logic           w_fifo_push;

            assign w_rdy[s]      = (r_cnt != 2'd2);
            assign w_push[s]     = w_in_vld[s] & w_rdy[s];
            assign w_head_vld[s] = (r_cnt != 2'd0);
            assign w_head_pld[s] = r_mem[r_rptr];
            // Bypass only when this FIFO is empty and the other lane has nothing queued
            assign w_byp[s]      = c_BYPASS & w_push[s] & ~w_head_vld[s] & ~w_head_vld[1-s];
            assign w_cand[s]     = w_head_vld[s] | w_byp[s];
            assign w_is_win      = w_grant & (w_win == 1'(s));
            assign w_pop         = w_is_win & w_head_vld[s];
            assign w_fifo_push   = w_push[s] & ~(w_is_win & ~w_head_vld[s]);

            always_ff @(posedge clk) begin
                if (w_fifo_push) begin
                    r_mem[r_wptr] <= w_in_pld[s];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wptr <= 1'b0;
                    r_rptr <= 1'b0;
                    r_cnt  <= 2'd0;
                end else begin
                    if (w_fifo_push) begin
                        r_wptr <= ~r_wptr;
                    end
                    if (w_pop) begin
                        r_rptr <= ~r_rptr;
                    end
                    r_cnt <= r_cnt + 2'(w_fifo_push) - 2'(w_pop);
                end
            end
        end
    endgenerate

    assign w_load_ok = ~r_out_vld | io.bank_req_rdy;
    assign w_grant   = w_load_ok & (|r_mask) & (|w_cand);
    assign w_win     = (&w_cand) ? ~r_last_grant : w_cand[1];

    assign w_win_pld = w_win ? (w_head_vld[1] ? w_head_pld[1] : w_in_pld[1])
                             : (w_head_vld[0] ? w_head_pld[0] : w_in_pld[0]);

    // Lowest-index free id wins; the downward scan leaves the smallest one last
    always_comb begin
        w_alloc_id = '0;
        for (int i = ROB_DEPTH - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_alloc_id = ROB_ID_W'(i);
            end
        end
    end

    always_comb begin
        w_grant_pld              = w_win_pld;
        w_grant_pld.rob_entry_id = c_ROB_FIELD_W'(w_alloc_id);
    end

    assign w_alloc_mask = w_grant ? (ROB_DEPTH'(1) << w_alloc_id) : '0;
    // A release of an id that is still free in the registered mask is dropped
    assign w_rel_eff    = io.rob_rel_vld & ~r_mask[io.rob_rel_id];
    assign w_rel_mask   = w_rel_eff ? (ROB_DEPTH'(1) << io.rob_rel_id) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask       <= '1;
            r_free_cnt   <= (ROB_ID_W+1)'(ROB_DEPTH);
            r_last_grant <= c_SRC_WR;
            r_out_vld    <= 1'b0;
            r_out_pld    <= '0;
        end else begin
            r_mask     <= (r_mask & ~w_alloc_mask) | w_rel_mask;
            r_free_cnt <= r_free_cnt - (ROB_ID_W+1)'(w_grant) + (ROB_ID_W+1)'(w_rel_eff);
            if (w_grant) begin
                r_last_grant <= w_win;
                r_out_vld    <= 1'b1;
                r_out_pld    <= w_grant_pld;
            end else if (io.bank_req_rdy) begin
                r_out_vld    <= 1'b0;
            end
        end
    end

    assign io.rd_req_rdy   = w_rdy[0];
    assign io.wr_req_rdy   = w_rdy[1];
    assign io.bank_req_vld = r_out_vld;
    assign io.bank_req_pld = r_out_pld;
    assign io.rob_free_cnt = r_free_cnt;

    logic w_unused;
    assign w_unused = c_SRC_RD;

endmodule
`default_nettype wire

// File: tb/tb_vec_cache_bank_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_cache_bank_req_arb
// Brief    : Scoreboard bench: a queue-based reference model predicts grants,
//            a negedge monitor compares every accepted bank request.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_cache_bank_req_arb;
    import vec_cache_bank_req_arb_pkg::*;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_ID_W  = 4;
`ifdef VEC_CACHE_REQ_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vec_cache_bank_req_arb_if #(.ROB_DEPTH(ROB_DEPTH)) u_if ();

    vec_cache_bank_req_arb #(.ROB_DEPTH(ROB_DEPTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (u_if.slave)
    );

    int checks   = 0;
    int failures = 0;

    input_req_pld_t       m_qr[$];
    input_req_pld_t       m_qw[$];
    input_req_pld_t       m_exp[$];
    logic [ROB_DEPTH-1:0] m_mask;
    bit                   m_last;
    bit                   m_out_vld;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int lowest_free(input logic [ROB_DEPTH-1:0] m);
        for (int i = 0; i < ROB_DEPTH; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic input_req_pld_t rand_pld();
        input_req_pld_t p;
        p.cmd_addr     = $urandom;
        p.cmd_txnid    = 8'($urandom);
        p.cmd_sideband = 4'($urandom);
        p.strb         = 16'($urandom);
        p.cmd_opcode   = 4'($urandom);
        p.db_entry_id  = 6'($urandom);
        p.rob_entry_id = 6'($urandom);
        return p;
    endfunction

    // Reference model: one step per clock edge from the inputs held during the cycle
    task automatic model_step();
        logic [ROB_DEPTH-1:0] pre;
        bit acc_r, acc_w, hr, hw, cr, cw, grant, win;
        input_req_pld_t p;
        int id;
        pre   = m_mask;
        acc_r = u_if.rd_req_vld && (m_qr.size() < 2);
        acc_w = u_if.wr_req_vld && (m_qw.size() < 2);
        hr    = m_qr.size() > 0;
        hw    = m_qw.size() > 0;
        cr    = hr || (BYP && acc_r && !hw);
        cw    = hw || (BYP && acc_w && !hr);
        grant = (!m_out_vld || u_if.bank_req_rdy) && (pre != 0) && (cr || cw);
        win   = (cr && cw) ? !m_last : cw;
        if (grant) begin
            if (!win) begin
                if (hr) p = m_qr.pop_front();
                else begin p = u_if.rd_req_pld; acc_r = 0; end
            end else begin
                if (hw) p = m_qw.pop_front();
                else begin p = u_if.wr_req_pld; acc_w = 0; end
            end
            id = lowest_free(pre);
            p.rob_entry_id = 6'(id);
            m_exp.push_back(p);
            m_mask[id] = 1'b0;
            m_last     = win;
            m_out_vld  = 1'b1;
        end else if (u_if.bank_req_rdy) begin
            m_out_vld = 1'b0;
        end
        if (acc_r) m_qr.push_back(u_if.rd_req_pld);
        if (acc_w) m_qw.push_back(u_if.wr_req_pld);
        if (u_if.rob_rel_vld && !pre[u_if.rob_rel_id]) m_mask[u_if.rob_rel_id] = 1'b1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_qr.delete();
            m_qw.delete();
            m_exp.delete();
            m_mask    = '1;
            m_last    = 1'b1;
            m_out_vld = 1'b0;
        end else begin
            model_step();
        end
    end

    // Monitor
    always @(negedge clk) begin
        input_req_pld_t e;
        if (rst_n) begin
            chk("rd_req_rdy", 64'(u_if.rd_req_rdy), 64'(m_qr.size() != 2));
            chk("wr_req_rdy", 64'(u_if.wr_req_rdy), 64'(m_qw.size() != 2));
            chk("rob_free_cnt", 64'(u_if.rob_free_cnt), 64'($countones(m_mask)));
            chk("bank_req_vld", 64'(u_if.bank_req_vld), 64'(m_out_vld));
            if (u_if.bank_req_vld && u_if.bank_req_rdy) begin
                checks++;
                if (m_exp.size() == 0) begin
                    failures++;
                    $display("FAIL bank_req_unexpected actual=%h required=none", u_if.bank_req_pld);
                end else begin
                    e = m_exp.pop_front();
                    if (u_if.bank_req_pld !== e) begin
                        failures++;
                        $display("FAIL bank_req_pld actual=%h required=%h", u_if.bank_req_pld, e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        u_if.rd_req_vld   = 1'b0;
        u_if.wr_req_vld   = 1'b0;
        u_if.rob_rel_vld  = 1'b0;
        u_if.bank_req_rdy = 1'b1;
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        idle();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic pick_release();
        int start;
        int id;
        u_if.rob_rel_vld = 1'b0;
        if ($urandom_range(3) != 0) return;
        if ($urandom_range(7) == 0) begin
            u_if.rob_rel_vld = 1'b1;
            u_if.rob_rel_id  = ROB_ID_W'($urandom);
            return;
        end
        start = $urandom_range(ROB_DEPTH - 1);
        for (int k = 0; k < ROB_DEPTH; k++) begin
            id = (start + k) % ROB_DEPTH;
            if (!m_mask[id]) begin
                u_if.rob_rel_vld = 1'b1;
                u_if.rob_rel_id  = ROB_ID_W'(id);
                return;
            end
        end
    endtask

    input_req_pld_t snap;

    initial begin
        u_if.rd_req_pld = '0;
        u_if.wr_req_pld = '0;
        u_if.rob_rel_id = '0;
        idle();
        step();
        step();
        // Reset values
        chk("reset_bank_vld", 64'(u_if.bank_req_vld), 64'd0);
        chk("reset_bank_pld", 64'(u_if.bank_req_pld), 64'd0);
        chk("reset_free_cnt", 64'(u_if.rob_free_cnt), 64'd16);
        chk("reset_rd_rdy", 64'(u_if.rd_req_rdy), 64'd1);
        rst_n = 1'b1;
        step();

        // Single read: addr 0x40, txnid 5
        u_if.rd_req_pld           = rand_pld();
        u_if.rd_req_pld.cmd_addr  = 32'h40;
        u_if.rd_req_pld.cmd_txnid = 8'd5;
        u_if.rd_req_vld           = 1'b1;
        step();
        u_if.rd_req_vld = 1'b0;
        chk("lat_t1_vld", 64'(u_if.bank_req_vld), 64'(BYP));
        if (!BYP) step();
        chk("lat_vld", 64'(u_if.bank_req_vld), 64'd1);
        chk("lat_rob_id", 64'(u_if.bank_req_pld.rob_entry_id), 64'd0);
        chk("lat_txnid", 64'(u_if.bank_req_pld.cmd_txnid), 64'd5);
        chk("lat_addr", 64'(u_if.bank_req_pld.cmd_addr), 64'h40);
        chk("lat_free_cnt", 64'(u_if.rob_free_cnt), 64'd15);
        step();

        // Tie: read wins first, then alternate
        do_reset();
        for (int i = 0; i < 4; i++) begin
            u_if.rd_req_vld = 1'b1;
            u_if.wr_req_vld = 1'b1;
            u_if.rd_req_pld = rand_pld();
            u_if.wr_req_pld = rand_pld();
            step();
        end
        idle();
        repeat (8) step();

        // ROB exhaustion and single release
        do_reset();
        u_if.rd_req_vld = 1'b1;
        for (int i = 0; i < 24; i++) begin
            u_if.rd_req_pld = rand_pld();
            step();
            while (!u_if.rd_req_rdy && i < 23) begin
                u_if.rd_req_vld = 1'b0;
                break;
            end
            u_if.rd_req_vld = u_if.rd_req_rdy;
        end
        u_if.rd_req_vld = 1'b0;
        step();
        chk("exh_free_cnt", 64'(u_if.rob_free_cnt), 64'd0);
        chk("exh_rd_rdy", 64'(u_if.rd_req_rdy), 64'd0);
        chk("exh_vld", 64'(u_if.bank_req_vld), 64'd0);
        u_if.rob_rel_vld = 1'b1;
        u_if.rob_rel_id  = 4'd7;
        step();
        u_if.rob_rel_vld = 1'b0;
        chk("rel_same_cycle_vld", 64'(u_if.bank_req_vld), 64'd0);
        step();
        chk("rel_next_vld", 64'(u_if.bank_req_vld), 64'd1);
        chk("rel_next_id", 64'(u_if.bank_req_pld.rob_entry_id), 64'd7);

        // Back-pressure
        do_reset();
        u_if.bank_req_rdy = 1'b0;
        u_if.rd_req_vld   = 1'b1;
        u_if.wr_req_vld   = 1'b1;
        u_if.rd_req_pld   = rand_pld();
        u_if.wr_req_pld   = rand_pld();
        step();
        step();
        snap = u_if.bank_req_pld;
        for (int i = 0; i < 5; i++) begin
            u_if.rd_req_pld = rand_pld();
            u_if.wr_req_pld = rand_pld();
            step();
        end
        chk("bp_vld", 64'(u_if.bank_req_vld), 64'd1);
        checks++;
        if (u_if.bank_req_pld !== snap) begin
            failures++;
            $display("FAIL bp_stable actual=%h required=%h", u_if.bank_req_pld, snap);
        end
        chk("bp_rd_rdy", 64'(u_if.rd_req_rdy), 64'd0);
        chk("bp_wr_rdy", 64'(u_if.wr_req_rdy), 64'd0);
        idle();
        repeat (10) step();

        // Double release of a free id
        do_reset();
        u_if.rob_rel_vld = 1'b1;
        u_if.rob_rel_id  = 4'd3;
        step();
        idle();
        chk("dbl_rel_cnt", 64'(u_if.rob_free_cnt), 64'd16);

        // Randomized traffic with a mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            u_if.rd_req_vld   = ($urandom_range(99) < 60);
            u_if.wr_req_vld   = ($urandom_range(99) < 60);
            u_if.rd_req_pld   = rand_pld();
            u_if.wr_req_pld   = rand_pld();
            u_if.bank_req_rdy = ($urandom_range(99) < 70);
            pick_release();
            step();
        end

        // Drain: release every outstanding id
        idle();
        for (int i = 0; i < 40; i++) begin
            u_if.rob_rel_vld = 1'b0;
            for (int id = 0; id < ROB_DEPTH; id++) begin
                if (!m_mask[id] && !u_if.rob_rel_vld) begin
                    u_if.rob_rel_vld = 1'b1;
                    u_if.rob_rel_id  = ROB_ID_W'(id);
                end
            end
            step();
        end
        idle();
        step();
        chk("drain_exp_empty", 64'(m_exp.size()), 64'd0);
        chk("drain_free_cnt", 64'(u_if.rob_free_cnt), 64'd16);
        chk("drain_vld", 64'(u_if.bank_req_vld), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
